snitch_icache_tag_ctrl: RTL
===========================

Name: snitch_icache_tag_ctrl

Overview:
Sequencer and arbiter for the instruction-cache tag memory (SET_COUNT single-port tag RAMs, 1-cycle read latency, entry = {valid, error, tag}).
- Shares the one tag port between the lookup path, the refill write path and a full invalidation sweep (flush).
- Compares read tags and returns per-set hit vectors.
- Sits between the icache lookup/refill stages and the tag memory wrapper.

Parameters:
SET_COUNT, 2, number of ways; each way is one tag RAM.
LINE_COUNT, 128, lines per way; power of two, at least 2.
TAG_WIDTH, 20, tag bits; RAM entry width is TAG_WIDTH+2.
COUNT_ALIGN, $clog2(LINE_COUNT), index width; derived, must not be overridden.
SET_ALIGN, max(1,$clog2(SET_COUNT)), set-select width; derived.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_valid_i  in  1  invalidate-all request
flush_ready_o  out  1  flush accept; high for exactly the cycle the request is taken
lookup_valid_i  in  1  lookup request
lookup_ready_o  out  1  lookup accepted
lookup_addr_i  in  COUNT_ALIGN  line index
lookup_tag_i  in  TAG_WIDTH  tag to compare
rsp_valid_o  out  1  lookup result valid
rsp_hit_o  out  SET_COUNT  per-set hit
rsp_err_o  out  1  error bit of the hitting entry
write_valid_i  in  1  refill tag write
write_ready_o  out  1  write accepted
write_addr_i  in  COUNT_ALIGN  line index
write_set_i  in  SET_ALIGN  target way
write_tag_i  in  TAG_WIDTH  tag
write_err_i  in  1  error flag stored with the tag
busy_o  out  1  sweep in progress
ram_enable_o  out  SET_COUNT  per-way RAM enable
ram_write_o  out  1  RAM write enable
ram_addr_o  out  COUNT_ALIGN  RAM address
ram_wtag_o  out  SET_COUNT x (TAG_WIDTH+2)  per-way write data; bit TAG_WIDTH+1 = valid, bit TAG_WIDTH = error
ram_rtag_i  in  SET_COUNT x (TAG_WIDTH+2)  per-way read data, valid one cycle after the read enable

Behaviour:
- States:
  - INIT: exists only with the optional feature.
  - RUN.
  - SWEEP.
- Reset values: all outputs 0; sweep counter 0; response register clear. Reset asserted mid-sweep aborts the sweep. After reset the block enters INIT or RUN, as set by the optional feature.
- RUN, fixed priority flush > write > lookup; at most one RAM access per cycle.
  - flush: flush_ready_o=1, go to SWEEP next cycle.
  - write: write_ready_o=1 when write_valid_i and no flush_valid_i. Drives ram_enable_o = one-hot(write_set_i), ram_write_o=1, ram_addr_o=write_addr_i, ram_wtag_o[set]={1,write_err_i,write_tag_i}.
  - lookup: lookup_ready_o=1 only when no flush and no write is requested. Drives ram_enable_o=all ones, ram_write_o=0, ram_addr_o=lookup_addr_i. Registers lookup_tag_i.
- Ready signals depend combinationally on the valids. The block never stalls a requester except for the priority rules and SWEEP.
- Lookup response:
  - rsp_valid_o=1 exactly one cycle after the accepted lookup; no backpressure.
  - rsp_hit_o[i] = ram_rtag_i[i] valid bit AND tag field equals the registered tag.
  - rsp_err_o = OR over hit ways of the error bits.
  - rsp_hit_o and rsp_err_o are 0 whenever rsp_valid_o=0.
- Write-then-lookup to the same index in consecutive cycles returns the new tag; the RAM provides this, no forwarding is needed.
- Two ways hitting at once: both rsp_hit_o bits are set; no arbitration.
- SWEEP:
  - busy_o=1. Each cycle: ram_enable_o=all ones, ram_write_o=1, ram_addr_o=counter, ram_wtag_o=0.
  - Counter increments each cycle. Counter = LINE_COUNT-1 is the last sweep cycle; it wraps to 0 and the next state is RUN.
  - Duration is exactly LINE_COUNT cycles. All ready signals are 0 throughout.
  - flush_valid_i during SWEEP is not accepted; it is taken again in RUN.
- A lookup accepted in the cycle before SWEEP still returns its response in the first SWEEP cycle.

Optional Feature:
SNITCH_ICACHE_TAG_CTRL_INIT_EN
- Defined: after reset release the block enters INIT. INIT behaves like SWEEP (busy_o=1, LINE_COUNT zero-write cycles), then goes to RUN; flush_ready_o stays 0 in INIT.
- Undefined: the block leaves reset directly in RUN. Tag RAM contents are undefined until software issues a flush.

Test Plan:
- Reset, feature defined, LINE_COUNT=128 -> busy_o=1 for exactly 128 cycles, ram_addr_o 0..127 with ram_write_o=1, then all ready signals usable.
- Write addr=5, set=1, tag=0xABCDE, err=0; next cycle lookup addr=5, tag=0xABCDE -> rsp_valid_o one cycle after accept, rsp_hit_o=2'b10, rsp_err_o=0; lookup with tag=0xABCDF -> rsp_hit_o=2'b00.
- write_valid_i and lookup_valid_i in the same cycle -> write_ready_o=1, lookup_ready_o=0; lookup accepted the following cycle.
- Write addr=9, set=0, err=1, then lookup hit -> rsp_hit_o=2'b01, rsp_err_o=1.
- flush_valid_i together with write and lookup -> only flush_ready_o=1; busy_o=1 for 128 cycles; then a lookup of previously written addr=5 -> rsp_hit_o=0.
- rst_ni asserted at sweep counter=60 -> outputs 0 immediately (asynchronous); after release, INIT restarts from address 0.

Source files
------------

// File: rtl/snitch_icache_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snitch_icache_tag_ctrl
// Purpose  : Sequencer and arbiter for the instruction-cache tag memory.
//            One shared port into SET_COUNT single-port tag RAMs (1-cycle
//            read latency, entry = {valid, error, tag}) is multiplexed
//            between a full invalidation sweep (flush), refill tag writes
//            and lookups, with fixed priority flush > write > lookup.
//            Lookup read data is compared against the registered tag and
//            returned as a per-way hit vector one cycle after acceptance.
//
// Ports    : clk_i, rst_ni            clock, asynchronous active-low reset
//            flush_valid_i/_ready_o   invalidate-all handshake
//            lookup_*                 lookup request (index + tag)
//            rsp_valid_o/hit_o/err_o  lookup result, one cycle after accept
//            write_*                  refill tag write (index, way, tag, err)
//            busy_o                   invalidation sweep in progress
//            ram_*                    tag RAM port (enable per way, shared
//                                     write enable / address, per-way data)
//
// Options  : SNITCH_ICACHE_TAG_CTRL_INIT_EN
//              defined   - after reset release an INIT sweep clears every
//                          line (LINE_COUNT cycles) before RUN is entered.
//              undefined - the block leaves reset directly in RUN; tag RAM
//                          contents are undefined until a flush is issued.
//
// Revision : 1.0 - initial release
// ============================================================================
module snitch_icache_tag_ctrl #(
  parameter int unsigned SET_COUNT   = 2,
  parameter int unsigned LINE_COUNT  = 128,
  parameter int unsigned TAG_WIDTH   = 20,
  // Derived widths; leave at their defaults.
  parameter int unsigned COUNT_ALIGN = $clog2(LINE_COUNT),
  parameter int unsigned SET_ALIGN   = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  // Flush (invalidate all)
  input  logic                                      flush_valid_i,
  output logic                                      flush_ready_o,
  // Lookup request
  input  logic                                      lookup_valid_i,
  output logic                                      lookup_ready_o,
  input  logic [COUNT_ALIGN-1:0]                    lookup_addr_i,
  input  logic [TAG_WIDTH-1:0]                      lookup_tag_i,
  // Lookup response
  output logic                                      rsp_valid_o,
  output logic [SET_COUNT-1:0]                      rsp_hit_o,
  output logic                                      rsp_err_o,
  // Refill tag write
  input  logic                                      write_valid_i,
  output logic                                      write_ready_o,
  input  logic [COUNT_ALIGN-1:0]                    write_addr_i,
  input  logic [SET_ALIGN-1:0]                      write_set_i,
  input  logic [TAG_WIDTH-1:0]                      write_tag_i,
  input  logic                                      write_err_i,
  // Status
  output logic                                      busy_o,
  // Tag RAM port
  output logic [SET_COUNT-1:0]                      ram_enable_o,
  output logic                                      ram_write_o,
  output logic [COUNT_ALIGN-1:0]                    ram_addr_o,
  output logic [SET_COUNT-1:0][TAG_WIDTH+1:0]       ram_wtag_o,
  input  logic [SET_COUNT-1:0][TAG_WIDTH+1:0]       ram_rtag_i
);

  localparam int unsigned ENTRY_WIDTH = TAG_WIDTH + 2;

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_SWEEP = 2'd2;
`ifdef SNITCH_ICACHE_TAG_CTRL_INIT_EN
  localparam logic [1:0] c_ST_INIT  = 2'd0;
  localparam logic [1:0] c_ST_RESET = c_ST_INIT;
`else
  localparam logic [1:0] c_ST_RESET = c_ST_RUN;
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]             state_q, state_d;
  logic [COUNT_ALIGN-1:0] cnt_q, cnt_d;        // sweep line counter
  logic                   rsp_valid_q, rsp_valid_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;        // tag of the lookup in flight

  // --------------------------------------------------------------------------
  // Combinational request/port signals (before reset gating)
  // --------------------------------------------------------------------------
  logic                                w_flush_ready;
  logic                                w_write_ready;
  logic                                w_lookup_ready;
  logic                                w_busy;
  logic [SET_COUNT-1:0]                w_ram_enable;
  logic                                w_ram_write;
  logic [COUNT_ALIGN-1:0]              w_ram_addr;
  logic [SET_COUNT-1:0][ENTRY_WIDTH-1:0] w_ram_wtag;
  logic [SET_COUNT-1:0]                w_set_oh;
  logic [SET_COUNT-1:0]                w_hit;
  logic [SET_COUNT-1:0]                w_err_bits;

  // One-hot way select for refill writes; an out-of-range way selects nothing.
  assign w_set_oh = SET_COUNT'(1) << write_set_i;

  // --------------------------------------------------------------------------
  // Sequencer / arbiter
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rsp_valid_d    = 1'b0;
    tag_d          = tag_q;
    w_flush_ready  = 1'b0;
    w_write_ready  = 1'b0;
    w_lookup_ready = 1'b0;
    w_busy         = 1'b0;
    w_ram_enable   = '0;
    w_ram_write    = 1'b0;
    w_ram_addr     = '0;
    w_ram_wtag     = '0;

    case (state_q)
      c_ST_RUN: begin
        if (flush_valid_i) begin
          // The flush itself uses no RAM cycle; the sweep starts next cycle
          // from line 0 (the counter always rests at 0 outside a sweep).
          w_flush_ready = 1'b1;
          state_d       = c_ST_SWEEP;
        end else if (write_valid_i) begin
          w_write_ready = 1'b1;
          w_ram_enable  = w_set_oh;
          w_ram_write   = 1'b1;
          w_ram_addr    = write_addr_i;
          for (int i = 0; i < SET_COUNT; i++) begin
            if (w_set_oh[i]) begin
              w_ram_wtag[i] = {1'b1, write_err_i, write_tag_i};
            end
          end
        end else if (lookup_valid_i) begin
          // All ways are read in parallel; compare happens next cycle.
          w_lookup_ready = 1'b1;
          w_ram_enable   = '1;
          w_ram_addr     = lookup_addr_i;
          rsp_valid_d    = 1'b1;
          tag_d          = lookup_tag_i;
        end
      end

`ifdef SNITCH_ICACHE_TAG_CTRL_INIT_EN
      c_ST_INIT,
`endif
      c_ST_SWEEP: begin
        // Zero-write one line in every way per cycle. LINE_COUNT is a power
        // of two, so the counter wraps back to 0 on the last line.
        w_busy       = 1'b1;
        w_ram_enable = '1;
        w_ram_write  = 1'b1;
        w_ram_addr   = cnt_q;
        cnt_d        = cnt_q + COUNT_ALIGN'(1);
        if (&cnt_q) begin
          state_d = c_ST_RUN;
        end
      end

      default: begin
        state_d = c_ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= c_ST_RESET;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      tag_q       <= tag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Tag compare on the RAM read data returned for the lookup in flight
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < SET_COUNT; i++) begin : g_way
    assign w_hit[i]      = rsp_valid_q
                         & ram_rtag_i[i][ENTRY_WIDTH-1]
                         & (ram_rtag_i[i][TAG_WIDTH-1:0] == tag_q);
    assign w_err_bits[i] = ram_rtag_i[i][TAG_WIDTH];
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_hit_o   = w_hit;
  assign rsp_err_o   = |(w_hit & w_err_bits);

  // --------------------------------------------------------------------------
  // Outputs. The ready and RAM signals are partly combinational from the
  // request valids, so they are forced low while reset is asserted; this
  // keeps every output at 0 immediately on reset assertion (including the
  // INIT state, which is the reset state when the init sweep is enabled).
  // --------------------------------------------------------------------------
  assign flush_ready_o  = rst_ni & w_flush_ready;
  assign write_ready_o  = rst_ni & w_write_ready;
  assign lookup_ready_o = rst_ni & w_lookup_ready;
  assign busy_o         = rst_ni & w_busy;
  assign ram_enable_o   = w_ram_enable & {SET_COUNT{rst_ni}};
  assign ram_write_o    = rst_ni & w_ram_write;
  assign ram_addr_o     = w_ram_addr & {COUNT_ALIGN{rst_ni}};
  assign ram_wtag_o     = w_ram_wtag & {(SET_COUNT*ENTRY_WIDTH){rst_ni}};

endmodule
`default_nettype wire
